// File: rtl/reflet_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding, master
// indices and the hold-counter width helper.
package reflet_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Wide enough to hold hold_max-1, never narrower than one bit.
  function automatic int hold_width(input int hold_max);
    return (hold_max <= 2) ? 1 : $clog2(hold_max);
  endfunction

endpackage

// File: rtl/reflet_arb_hold_counter.sv
// Saturating up-counter with synchronous clear, tracking how long the current
// bus owner has held its grant.
module reflet_arb_hold_counter #(
  parameter int width   = 4,
  parameter int max_val = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] max_count = width'(max_val);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != max_count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Two-master round-robin bus arbiter with registered grants and a
// combinational bus mux. Define REFLET_ARB_PREEMPT_EN to enable hold-time preemption.
module reflet_bus_arbiter
  import reflet_arb_pkg::*;
#(
  parameter int wordsize = 8,
  parameter int hold_max = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic                m0_write_en,
  input  logic [wordsize-1:0] m0_data_out,
  output logic [wordsize-1:0] m0_data_in,
  output logic                m0_gnt,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic                m1_write_en,
  input  logic [wordsize-1:0] m1_data_out,
  output logic [wordsize-1:0] m1_data_in,
  output logic                m1_gnt,
  output logic [wordsize-1:0] bus_addr,
  output logic                bus_write_en,
  output logic [wordsize-1:0] bus_data_out,
  input  logic [wordsize-1:0] bus_data_in,
  output logic                owner
);

  if (hold_max < 1) begin : g_bad_hold_max
    $error("reflet_bus_arbiter: hold_max must be at least 1");
  end

  arb_state_t state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       hold_expired;

`ifdef REFLET_ARB_PREEMPT_EN
  localparam int hw = hold_width(hold_max);
  logic [hw-1:0] hold_count;

  // Restarts from zero whenever ownership changes, so the first owned cycle sees 0.
  reflet_arb_hold_counter #(
    .width  (hw),
    .max_val(hold_max - 1)
  ) u_hold_counter (
    .clk   (clk),
    .reset (reset),
    .clear (state_next != state_reg),
    .enable(state_reg != IDLE),
    .count (hold_count)
  );

  assign hold_expired = (hold_count == hw'(hold_max - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= M1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_next = (owner_reg == M1) ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_next = OWN0;
        end else if (m1_req) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_next = m1_req ? OWN1 : IDLE;
        end else if (hold_expired && m1_req) begin
          state_next = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_next = m0_req ? OWN0 : IDLE;
        end else if (hold_expired && m0_req) begin
          state_next = OWN0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == OWN0) begin
      owner_next = M0;
    end else if (state_next == OWN1) begin
      owner_next = M1;
    end
  end

  // Only the granted master sees the bus; everything else is forced to zero.
  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    bus_addr     = '0;
    bus_write_en = 1'b0;
    bus_data_out = '0;
    m0_data_in   = '0;
    m1_data_in   = '0;
    case (state_reg)
      OWN0: begin
        m0_gnt       = 1'b1;
        bus_addr     = m0_addr;
        bus_write_en = m0_write_en;
        bus_data_out = m0_data_out;
        m0_data_in   = bus_data_in;
      end
      OWN1: begin
        m1_gnt       = 1'b1;
        bus_addr     = m1_addr;
        bus_write_en = m1_write_en;
        bus_data_out = m1_data_out;
        m1_data_in   = bus_data_in;
      end
      default: ;
    endcase
  end

  assign owner = owner_reg;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Self-checking bench for reflet_bus_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural ownership model.
module tb_reflet_bus_arbiter;

  localparam int W    = 8;
  localparam int HOLD = 4;
`ifdef REFLET_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req, m0_write_en, m1_req, m1_write_en;
  logic [W-1:0] m0_addr, m0_data_out, m1_addr, m1_data_out, bus_data_in;
  logic [W-1:0] m0_data_in, m1_data_in, bus_addr, bus_data_out;
  logic         m0_gnt, m1_gnt, bus_write_en, owner;

  int tests  = 0;
  int failed = 0;

  // Model: holder is -1 when the bus is free, else the granted master index.
  int holder = -1;
  int mowner = 1;
  int held   = 0;

  always #5 clk = ~clk;

  reflet_bus_arbiter #(.wordsize(W), .hold_max(HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write_en(m0_write_en),
    .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write_en(m1_write_en),
    .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_gnt(m1_gnt),
    .bus_addr(bus_addr), .bus_write_en(bus_write_en), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decide who owns the bus after the coming edge from the arbitration rules.
  task automatic model_edge();
    int nh;
    bit rh, ro;
    if (reset) begin
      holder = -1; mowner = 1; held = 0;
      return;
    end
    if (holder == -1) begin
      if (m0_req && m1_req) nh = 1 - mowner;
      else if (m0_req)      nh = 0;
      else if (m1_req)      nh = 1;
      else                  nh = -1;
    end else begin
      rh = (holder == 0) ? m0_req : m1_req;
      ro = (holder == 0) ? m1_req : m0_req;
      if (!rh)                               nh = ro ? 1 - holder : -1;
      else if (PREEMPT && held >= HOLD && ro) nh = 1 - holder;
      else                                   nh = holder;
    end
    if (nh != holder) held = (nh == -1) ? 0 : 1;
    else if (nh != -1) held++;
    if (nh != -1) mowner = nh;
    holder = nh;
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e_addr, e_dout, e_d0, e_d1;
    logic         e_we;
    e_addr = '0; e_dout = '0; e_we = 1'b0; e_d0 = '0; e_d1 = '0;
    if (holder == 0) begin
      e_addr = m0_addr; e_dout = m0_data_out; e_we = m0_write_en; e_d0 = bus_data_in;
    end else if (holder == 1) begin
      e_addr = m1_addr; e_dout = m1_data_out; e_we = m1_write_en; e_d1 = bus_data_in;
    end
    chk({tag, ".m0_gnt"}, 32'(m0_gnt), 32'(holder == 0));
    chk({tag, ".m1_gnt"}, 32'(m1_gnt), 32'(holder == 1));
    chk({tag, ".owner"}, 32'(owner), 32'(mowner));
    chk({tag, ".bus_addr"}, 32'(bus_addr), 32'(e_addr));
    chk({tag, ".bus_we"}, 32'(bus_write_en), 32'(e_we));
    chk({tag, ".bus_dout"}, 32'(bus_data_out), 32'(e_dout));
    chk({tag, ".m0_din"}, 32'(m0_data_in), 32'(e_d0));
    chk({tag, ".m1_din"}, 32'(m1_data_in), 32'(e_d1));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    step("reset");
    reset = 1'b0;
  endtask

  initial begin
    int run;
    reset = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_write_en = 1'b0; m0_data_out = '0;
    m1_req = 1'b0; m1_addr = '0; m1_write_en = 1'b0; m1_data_out = '0;
    bus_data_in = '0;
    #2;
    do_reset();
    chk("reset.owner_is_1", 32'(owner), 32'd1);
    chk("reset.bus_we_0", 32'(bus_write_en), 32'd0);

    // Single request: one-cycle grant latency, write not visible before grant.
    m0_req = 1'b1; m0_addr = 8'h81; m0_write_en = 1'b1; m0_data_out = 8'h5A;
    bus_data_in = 8'h33;
    #1;
    check_all("single.pre");
    step("single.gnt");
    chk("single.bus_addr_81", 32'(bus_addr), 32'h81);
    chk("single.bus_dout_5a", 32'(bus_data_out), 32'h5A);
    chk("single.m1_din_0", 32'(m1_data_in), 32'h0);
    $display("[TB] single request: m0_gnt=%0b bus_addr=%0h", m0_gnt, bus_addr);

    // Tie after reset, handover without bubble, next tie goes to M0.
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_write_en = 1'b0;
    step("tie1");
    chk("tie1.m0_wins", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    step("handover");
    chk("handover.m1_gnt", 32'(m1_gnt), 32'd1);
    m1_addr = 8'h42; m1_write_en = 1'b0; bus_data_in = 8'hCD;
    #1;
    check_all("readback");
    chk("readback.m1_din_cd", 32'(m1_data_in), 32'hCD);
    chk("readback.m0_din_0", 32'(m0_data_in), 32'h00);
    m1_req = 1'b0;
    step("release");
    chk("release.owner_held", 32'(owner), 32'd1);
    m0_req = 1'b1; m1_req = 1'b1;
    step("tie2");
    chk("tie2.m0_wins", 32'(m0_gnt), 32'd1);
    $display("[TB] tie sequence: m0_gnt=%0b owner=%0b", m0_gnt, owner);

    // Contended hold: preempted after HOLD cycles, or kept for 100 cycles.
    do_reset();
    m0_req = 1'b1;
    step("hold.first");
    run = m0_gnt ? 1 : 0;
    m1_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step("hold.loop");
      if (!m0_gnt) break;
      run++;
    end
    chk("hold.run_length", 32'(run), PREEMPT ? 32'(HOLD) : 32'd101);
    $display("[TB] contended hold: m0 owned bus %0d cycles", run);

    // Reset pulsed while M1 is writing.
    do_reset();
    m1_req = 1'b1; m1_write_en = 1'b1; m1_addr = 8'h10; m1_data_out = 8'hEE;
    step("rstmid.grant");
    chk("rstmid.m1_writing", 32'(bus_write_en), 32'd1);
    reset = 1'b1;
    step("rstmid.edge");
    chk("rstmid.m1_gnt_0", 32'(m1_gnt), 32'd0);
    chk("rstmid.bus_we_0", 32'(bus_write_en), 32'd0);
    reset = 1'b0; m1_req = 1'b0;
    step("rstmid.after");
    chk("rstmid.owner_1", 32'(owner), 32'd1);
    $display("[TB] reset mid-write: m1_gnt=%0b owner=%0b", m1_gnt, owner);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) == 0);
      m0_req      = ($urandom_range(0, 3) != 0);
      m1_req      = ($urandom_range(0, 3) != 0);
      m0_write_en = 1'($urandom);
      m1_write_en = 1'($urandom);
      m0_addr     = W'($urandom);
      m1_addr     = W'($urandom);
      m0_data_out = W'($urandom);
      m1_data_out = W'($urandom);
      bus_data_in = W'($urandom);
      step("random");
    end
    $display("[TB] random traffic: 400 cycles");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
